// File: rtl/gcd_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gcd_sched_pkg
// Description : Shared types and constants for the GCD scheduler: FSM state
//               encoding, default parameter values and the requester-id
//               width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package gcd_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam int C_DEF_WIDTH   = 8;
    localparam int C_DEF_NREQ    = 4;
    localparam int C_DEF_TIMEOUT = 1024;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gcd_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Searches i_req starting at
//               i_ptr and moving upward with wrap; the first set bit wins.
// Ports       : i_req   [NREQ]  request vector
//               i_ptr   [IDW]   highest-priority index (must be < NREQ)
//               o_grant [NREQ]  one-hot grant (all zero when no request)
//               o_idx   [IDW]   index of the granted requester
//               o_any   [1]     at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import gcd_sched_pkg::*;
#(
    parameter  int NREQ = C_DEF_NREQ,
    localparam int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);

    always_comb begin
        int j;
        j       = 0;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(i_ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!o_any && i_req[j]) begin
                o_any      = 1'b1;
                o_grant[j] = 1'b1;
                o_idx      = IDW'(j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gcd_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : gcd_scheduler
// Description : Shares one multi-cycle GCD engine between NREQ requesters.
//               Round-robin accept in IDLE, one-cycle engine start, bounded
//               wait for done (abort on timeout), then a held response until
//               the consumer accepts it. Zero operands bypass the engine.
// Ports       : clock, reset_n               clock / async active-low reset
//               req_valid/ready/a/b          requester handshake, packed by id
//               rsp_valid/ready/id/result/err response handshake
//               gcd_start/a/b/abort          engine control (owned here)
//               gcd_done/outp                engine completion and result
// Revision    : 1.0 - initial release
// ============================================================================
module gcd_scheduler
    import gcd_sched_pkg::*;
#(
    parameter  int WIDTH   = C_DEF_WIDTH,
    parameter  int NREQ    = C_DEF_NREQ,
    parameter  int TIMEOUT = C_DEF_TIMEOUT,
    localparam int IDW     = id_width(NREQ)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_result,
    output logic                  rsp_err,
    output logic                  gcd_start,
    output logic [WIDTH-1:0]      gcd_a,
    output logic [WIDTH-1:0]      gcd_b,
    output logic                  gcd_abort,
    input  logic                  gcd_done,
    input  logic [WIDTH-1:0]      gcd_outp
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDW-1:0]   r_rr_ptr;
    logic [IDW-1:0]   r_id;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic             r_err;
    logic [CW-1:0]    r_cnt;

    logic [NREQ-1:0]  w_grant;
    logic [IDW-1:0]   w_idx;
    logic             w_any;
    logic [WIDTH-1:0] w_win_a;
    logic [WIDTH-1:0] w_win_b;
    logic             w_zero;
    logic             w_accept;
    logic             w_timeout;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_win_a   = req_a[w_idx*WIDTH +: WIDTH];
    assign w_win_b   = req_b[w_idx*WIDTH +: WIDTH];
    assign w_zero    = (w_win_a == '0) || (w_win_b == '0);
    // Timeout is only taken when done is absent in the same cycle.
    assign w_timeout = (r_cnt == CW'(TIMEOUT - 1)) && !gcd_done;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        req_ready   = '0;
        gcd_start   = 1'b0;
        gcd_abort   = 1'b0;
        rsp_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = w_grant;
                if (w_any) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_zero ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                gcd_start   = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (gcd_done) begin
                    w_state_nxt = ST_RESP;
                end else if (w_timeout) begin
                    gcd_abort   = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr <= '0;
            r_id     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (w_accept) begin
                r_id     <= w_idx;
                r_a      <= w_win_a;
                r_b      <= w_win_b;
                r_rr_ptr <= (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
                if (w_zero) begin
                    r_result <= '0;
                    r_err    <= 1'b0;
                end
            end
            // The counter never passes TIMEOUT-1: WAIT always exits there.
            if (r_state == ST_ISSUE) begin
                r_cnt <= '0;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == ST_WAIT) begin
                if (gcd_done) begin
                    r_result <= gcd_outp;
                    r_err    <= 1'b0;
                end else if (w_timeout) begin
                    r_result <= '0;
                    r_err    <= 1'b1;
                end
            end
        end
    end

    assign gcd_a      = r_a;
    assign gcd_b      = r_b;
    assign rsp_id     = r_id;
    assign rsp_result = r_result;
    assign rsp_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_gcd_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_gcd_scheduler
// Description : Scoreboard bench for gcd_scheduler with a behavioural GCD
//               engine, a round-robin reference model and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gcd_scheduler;

    localparam int WIDTH   = 8;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;
    localparam int IDW     = 2;

    logic                  clock;
    logic                  reset_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_result;
    logic                  rsp_err;
    logic                  gcd_start;
    logic [WIDTH-1:0]      gcd_a;
    logic [WIDTH-1:0]      gcd_b;
    logic                  gcd_abort;
    logic                  gcd_done;
    logic [WIDTH-1:0]      gcd_outp;

    gcd_scheduler #(
        .WIDTH   (WIDTH),
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .gcd_start  (gcd_start),
        .gcd_a      (gcd_a),
        .gcd_b      (gcd_b),
        .gcd_abort  (gcd_abort),
        .gcd_done   (gcd_done),
        .gcd_outp   (gcd_outp)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference GCD (Euclid by remainder).
    function automatic int ref_gcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Engine-side GCD (subtraction form).
    function automatic int sub_gcd(input int a, input int b);
        if (a == 0) return b;
        if (b == 0) return a;
        while (a != b) begin
            if (a > b) a = a - b;
            else       b = b - a;
        end
        return a;
    endfunction

    // Engine behaviour per request: 0 normal, 1 never done, 2 done on timeout cycle.
    int m_mode [NREQ];
    int mon_mode = 0;
    int bp_mode  = 0;
    int spur_cnt = 0;

    typedef struct {
        int id;
        int res;
        int err;
    } rsp_t;

    rsp_t   exp_q[$];
    int     grant_log[$];
    bit     in_flight = 1'b0;
    longint cyc = 0;
    longint acc_cyc = 0;
    longint start_cyc = -1;
    longint abort_cyc = -1;
    longint rsp_cyc = -1;
    int     m_ptr = 0;
    int     exp_a = 0;
    int     exp_b = 0;

    // Response consumer.
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            case (bp_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = 1'b0;
                default: rsp_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // Behavioural GCD engine.
    initial begin : engine
        int a, b, k, md, spur_seen;
        bit live;
        spur_seen = 0;
        gcd_done  = 1'b0;
        gcd_outp  = '0;
        forever begin
            @(negedge clock);
            if (reset_n && gcd_start) begin
                a    = int'(gcd_a);
                b    = int'(gcd_b);
                md   = mon_mode;
                live = 1'b1;
                k    = (md == 0) ? int'($urandom_range(0, TIMEOUT - 2)) : TIMEOUT - 1;
                for (int j = 0; j <= k; j++) begin
                    @(posedge clock);
                    #2;
                    if (!reset_n) begin
                        live = 1'b0;
                        break;
                    end
                    chk("gcd_a_hold", gcd_a, a);
                    chk("gcd_b_hold", gcd_b, b);
                end
                if (live && md != 1) begin
                    gcd_done = 1'b1;
                    gcd_outp = WIDTH'(sub_gcd(a, b));
                    @(posedge clock);
                    #2;
                    gcd_done = 1'b0;
                    gcd_outp = WIDTH'($urandom);
                end
            end else if (spur_seen != spur_cnt) begin
                spur_seen = spur_cnt;
                @(posedge clock);
                #2;
                gcd_done = 1'b1;
                gcd_outp = 8'hA5;
                @(posedge clock);
                #2;
                gcd_done = 1'b0;
            end
        end
    end

    // Monitor: reference arbitration model, timing expectations, scoreboard.
    always @(negedge clock) begin : monitor
        int w, a, b;
        logic [NREQ-1:0] eg;
        rsp_t r;
        cyc++;
        if (!reset_n) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_result", rsp_result, 0);
            chk("rst_rsp_err", rsp_err, 0);
            chk("rst_gcd_start", gcd_start, 0);
            chk("rst_gcd_abort", gcd_abort, 0);
            chk("rst_gcd_a", gcd_a, 0);
            chk("rst_gcd_b", gcd_b, 0);
            exp_q.delete();
            in_flight = 1'b0;
            m_ptr     = 0;
            start_cyc = -1;
            abort_cyc = -1;
            rsp_cyc   = -1;
        end else begin
            w  = -1;
            eg = '0;
            if (!in_flight && req_valid != '0) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (w < 0 && req_valid[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
                end
                eg[w] = 1'b1;
            end
            chk("req_ready", req_ready, eg);
            chk("gcd_start", gcd_start, cyc == start_cyc);
            if (cyc == start_cyc) begin
                chk("gcd_a_issue", gcd_a, exp_a);
                chk("gcd_b_issue", gcd_b, exp_b);
            end
            chk("gcd_abort", gcd_abort, cyc == abort_cyc);
            chk("rsp_valid", rsp_valid, in_flight && rsp_cyc >= 0 && cyc >= rsp_cyc);
            if (rsp_valid && exp_q.size() > 0) begin
                r = exp_q[0];
                chk("rsp_id", rsp_id, r.id);
                chk("rsp_result", rsp_result, r.res);
                chk("rsp_err", rsp_err, r.err);
            end
            if (in_flight && gcd_done && rsp_cyc < 0 && cyc >= acc_cyc + 2) begin
                rsp_cyc = cyc + 1;
            end
            if (rsp_valid && rsp_ready && in_flight) begin
                void'(exp_q.pop_front());
                in_flight = 1'b0;
                start_cyc = -1;
                abort_cyc = -1;
                rsp_cyc   = -1;
            end
            if (w >= 0) begin
                a         = int'(req_a[w*WIDTH +: WIDTH]);
                b         = int'(req_b[w*WIDTH +: WIDTH]);
                r.id      = w;
                in_flight = 1'b1;
                acc_cyc   = cyc;
                m_ptr     = (w + 1) % NREQ;
                mon_mode  = m_mode[w];
                grant_log.push_back(w);
                if (a == 0 || b == 0) begin
                    r.res   = 0;
                    r.err   = 0;
                    rsp_cyc = cyc + 1;
                end else begin
                    exp_a     = a;
                    exp_b     = b;
                    start_cyc = cyc + 1;
                    if (m_mode[w] == 1) begin
                        r.res     = 0;
                        r.err     = 1;
                        abort_cyc = cyc + 1 + TIMEOUT;
                        rsp_cyc   = cyc + 2 + TIMEOUT;
                    end else begin
                        r.res = ref_gcd(a, b);
                        r.err = 0;
                    end
                end
                exp_q.push_back(r);
            end
        end
    end

    // Present a request and hold valid until it is accepted.
    task automatic do_req(input int id, input int a, input int b, input int mode);
        int n;
        n          = 0;
        m_mode[id] = mode;
        req_a[id*WIDTH +: WIDTH] = WIDTH'(a);
        req_b[id*WIDTH +: WIDTH] = WIDTH'(b);
        req_valid[id] = 1'b1;
        forever begin
            @(negedge clock);
            if (req_ready[id]) break;
            n++;
            if (n > 400) begin
                checks++;
                errors++;
                $display("FAIL accept_wait id=%0d: got no accept expected accept", id);
                break;
            end
        end
        @(posedge clock);
        #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(posedge clock);
            n++;
        end while ((in_flight || req_valid != '0) && n < 400);
        #1;
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: got busy expected idle");
        end
    endtask

    task automatic rand_req(input int id);
        int a, b, r;
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clock);
            #1;
            a = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255));
            b = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255));
            r = int'($urandom_range(0, 9));
            do_req(id, a, b, (r == 0) ? 1 : (r == 1) ? 2 : 0);
        end
    endtask

    initial begin : main
        int base, n;
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < NREQ; i++) m_mode[i] = 0;
        reset_n   = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Single request: gcd(48,18)=6 from requester 1.
        do_req(1, 48, 18, 0);
        wait_idle();

        // Zero-operand bypass from requester 2.
        do_req(2, 0, 35, 0);
        wait_idle();

        // Back-pressure: response held 10 cycles while requester 3 waits.
        @(negedge clock);
        bp_mode = 1;
        @(posedge clock);
        #1;
        do_req(2, 100, 75, 0);
        fork
            do_req(3, 12, 8, 0);
            begin
                n = 0;
                while (!rsp_valid && n < 100) begin
                    @(negedge clock);
                    n++;
                end
                chk("bp_rsp_seen", rsp_valid, 1);
                repeat (10) @(negedge clock);
                bp_mode = 0;
            end
        join
        wait_idle();

        // Round-robin with all requesters continuously valid.
        base = grant_log.size();
        fork
            begin do_req(0, 40, 24, 0); do_req(0, 81, 27, 0); end
            begin do_req(1, 35, 14, 0); do_req(1, 17, 5, 0);  end
            begin do_req(2, 64, 48, 0); do_req(2, 99, 33, 0); end
            begin do_req(3, 90, 60, 0); do_req(3, 7, 7, 0);   end
        join
        wait_idle();
        if (grant_log.size() >= base + 5) begin
            for (int i = 0; i < 5; i++) chk("rr_order", grant_log[base + i], exp_order[i]);
        end else begin
            checks++;
            errors++;
            $display("FAIL rr_count: got %0d expected 5", grant_log.size() - base);
        end

        // Timeout abort, then done coinciding with timeout.
        do_req(1, 30, 12, 1);
        wait_idle();
        do_req(1, 30, 12, 2);
        wait_idle();

        // Stray done while idle must be ignored.
        spur_cnt++;
        repeat (5) @(posedge clock);
        #1;

        // Reset during WAIT, then arbitration restarts from pointer 0.
        do_req(2, 77, 21, 1);
        repeat (4) @(posedge clock);
        #1;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        base = grant_log.size();
        fork
            do_req(1, 54, 24, 0);
            do_req(3, 26, 39, 0);
        join
        wait_idle();
        if (grant_log.size() >= base + 2) begin
            chk("post_rst_first", grant_log[base], 1);
            chk("post_rst_second", grant_log[base + 1], 3);
        end else begin
            checks++;
            errors++;
            $display("FAIL post_rst_count: got %0d expected 2", grant_log.size() - base);
        end

        // Randomized traffic with random back-pressure.
        bp_mode = 2;
        fork
            rand_req(0);
            rand_req(1);
            rand_req(2);
            rand_req(3);
        join
        bp_mode = 0;
        wait_idle();
        chk("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
